// File: rtl/pipe_pkg.sv
// Shared pipeline-control definitions: hazard FSM state encodings and the
// control word handed to the pipeline registers.
package pipe_pkg;

    // Encoding 3 is unused; the FSM steps out of it to RUN on the next edge.
    typedef enum logic [1:0] {
        RUN      = 2'd0,
        DIV_WAIT = 2'd1,
        FLUSH    = 2'd2,
        RSVD     = 2'd3
    } pipe_state_t;

    localparam int DIV_CNT_W = 6;

    // NOP-insertion contract with the datapath:
    //   stall_if_id : PC and IF/ID hold their contents
    //   bubble_ex   : ID/EX loads an all-zero control word (a NOP)
    //   flush_all   : IF/ID, ID/EX and EX/MEM load NOPs
    typedef struct packed {
        logic stall_if_id;
        logic bubble_ex;
        logic flush_all;
    } pipe_ctl_t;

    localparam pipe_ctl_t CTL_NONE = '0;

endpackage

// File: rtl/hazard_cmp.sv
// Source/destination register comparator: does the instruction in ID read
// the register that a later stage is about to write?
module hazard_cmp (
    input  logic [4:0] rs,
    input  logic [4:0] rt,
    input  logic       use_rs,
    input  logic       use_rt,
    input  logic [4:0] dest,
    output logic       hit
);

    // r0 is never a real dependency.
    assign hit = (dest != 5'd0) &
                 ((use_rs & (rs == dest)) | (use_rt & (rt == dest)));

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: load-use and branch-operand stalls, multi-cycle
// divide hold with a watchdog, and exception/eret flush.
//
//   state    | meaning
//   ---------+------------------------------------------------------------
//   RUN      | normal issue; stall/bubble only on load-use or branch hazard
//   DIV_WAIT | divider busy; front end held, EX keeps the divide
//   FLUSH    | one-cycle flush of IF/ID, ID/EX, EX/MEM after sweap
//   RSVD     | unused encoding; returns to RUN
module pipe_hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int CNT_W   = 16,
    parameter int DIV_MAX = 40
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_use_rs,
    input  logic             id_use_rt,
    input  logic             id_is_br,
    input  logic [4:0]       ex_dest,
    input  logic             ex_regwrite,
    input  logic             ex_memread,
    input  logic [4:0]       mem_dest,
    input  logic             mem_memread,
    input  logic             div_start,
    input  logic             div_complete,
    input  logic             sweap,
    output logic             stall_if_id,
    output logic             bubble_ex,
    output logic             flush_all,
    output logic             div_timeout,
    output logic [1:0]       state_o,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam logic [DIV_CNT_W-1:0] DIV_LAST = DIV_CNT_W'(DIV_MAX - 1);

    pipe_state_t          state;
    logic [DIV_CNT_W-1:0] div_cnt;
    logic                 hit_ex;
    logic                 hit_mem;
    logic                 load_use;
    logic                 br_haz;
    logic                 hazard;
    pipe_ctl_t            ctl;

    hazard_cmp u_cmp_ex (
        .rs     (id_rs),
        .rt     (id_rt),
        .use_rs (id_use_rs),
        .use_rt (id_use_rt),
        .dest   (ex_dest),
        .hit    (hit_ex)
    );

    hazard_cmp u_cmp_mem (
        .rs     (id_rs),
        .rt     (id_rt),
        .use_rs (id_use_rs),
        .use_rt (id_use_rt),
        .dest   (mem_dest),
        .hit    (hit_mem)
    );

    assign load_use = ex_memread & hit_ex;
    // A branch resolved in ID needs its operand now: an ALU result still in
    // EX, or load data still in MEM, are both too late to forward.
    assign br_haz   = id_is_br & ((ex_regwrite & hit_ex) | (mem_memread & hit_mem));
    assign hazard   = load_use | br_haz;

    // Control word from current state and this cycle's hazards; sweap wins.
    always_comb begin
        ctl = CTL_NONE;
        if (resetn) begin
            if (sweap) begin
                ctl.flush_all = 1'b1;
            end else begin
                case (state)
                    RUN: begin
                        ctl.stall_if_id = hazard;
                        ctl.bubble_ex   = hazard;
                    end
                    DIV_WAIT: ctl.stall_if_id = 1'b1;
                    FLUSH:    ctl.flush_all   = 1'b1;
                    default:  ctl = CTL_NONE;
                endcase
            end
        end
    end

    assign stall_if_id = ctl.stall_if_id;
    assign bubble_ex   = ctl.bubble_ex;
    assign flush_all   = ctl.flush_all;
    assign state_o     = state;

    // FSM, divide watchdog, sticky timeout flag and saturating stall counter.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state       <= RUN;
            div_cnt     <= '0;
            div_timeout <= 1'b0;
            stall_cnt   <= '0;
        end else begin
            if (ctl.stall_if_id && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
            if (sweap) begin
                state <= FLUSH;
            end else begin
                case (state)
                    RUN: begin
                        if (div_start) begin
                            state   <= DIV_WAIT;
                            div_cnt <= '0;
                        end
                    end
                    DIV_WAIT: begin
                        div_cnt <= div_cnt + DIV_CNT_W'(1);
                        if (div_complete) begin
                            state <= RUN;
                        end else if (div_cnt == DIV_LAST) begin
                            state       <= RUN;
                            div_timeout <= 1'b1;
                        end
                    end
                    default: state <= RUN;
                endcase
            end
        end
    end

endmodule
